mips_load_store_unit: RTL and testbench

//  Sits between the MIPS datapath and the word-wide, big-endian data RAM. The RAM has a 1-cycle registered read and a full-word write.
//  - Turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into RAM reads and writes.
//  - Uses read-modify-write for sub-word stores.
//  - Sign- or zero-extends load data and flags misaligned accesses.

---
 rtl/mips_mem_pkg.sv | 53 +++++
 rtl/mips_load_store_unit_if.sv | 32 +++
 rtl/mips_load_align.sv | 76 +++++++
 rtl/mips_load_store_unit.sv | 152 +++++++++++++++
 tb/tb_mips_load_store_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and op-decode helpers for the MIPS load/store unit.
// LWL/LWR are legal only when MIPS_LSU_UNALIGNED_EN is defined.
package mips_mem_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } mem_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCapture,
    StWrite,
    StResp
  } lsu_state_t;

  function automatic logic is_store(mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_legal(mem_op_t op);
    logic legal;
    case (op)
      LB, LBU, LH, LHU, LW, SB, SH, SW: legal = 1'b1;
`ifdef MIPS_LSU_UNALIGNED_EN
      LWL, LWR:                         legal = 1'b1;
`endif
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

  // LWL/LWR deliberately fall through: they address any byte.
  function automatic logic is_misaligned(mem_op_t op, logic [1:0] offset);
    logic mis;
    case (op)
      LH, LHU, SH: mis = offset[0];
      LW, SW:      mis = (offset != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// Request/response and data-RAM bundle of the MIPS load/store unit.
// master = datapath + RAM side, slave = the load/store unit.
interface mips_load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_a, mem_we, mem_wd, mem_byteenable
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rt_old, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_a, mem_we, mem_wd, mem_byteenable
  );

endinterface

// File: rtl/mips_load_align.sv
// Combinational byte-lane steering: load extract/extend and SB/SH merge.
// LWL/LWR merge is built only when MIPS_LSU_UNALIGNED_EN is defined.
module mips_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] rt_old,
  input  logic [15:0] wdata,
  output logic [31:0] result,
  output logic [31:0] merged,
  output logic [3:0]  byteenable
);

  // Big-endian: byte k lives at bit 8*(3-k), halfword k at 8*(2-k).
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_sh   = {~offset, 3'b000};
  assign half_sh   = {~offset[1], 4'b0000};
  assign byte_word = word >> byte_sh;
  assign half_word = word >> half_sh;
  assign sel_byte  = byte_word[7:0];
  assign sel_half  = half_word[15:0];

`ifdef MIPS_LSU_UNALIGNED_EN
  logic [4:0] lwl_sh;
  logic [4:0] lwr_sh;
  assign lwl_sh = {offset, 3'b000};
  assign lwr_sh = {~offset, 3'b000};
`else
  logic unused_rt;
  assign unused_rt = ^rt_old;
`endif

  always_comb begin
    result = '0;
    case (op)
      LB:      result = {{24{sel_byte[7]}}, sel_byte};
      LBU:     result = {24'b0, sel_byte};
      LH:      result = {{16{sel_half[15]}}, sel_half};
      LHU:     result = {16'b0, sel_half};
      LW:      result = word;
`ifdef MIPS_LSU_UNALIGNED_EN
      LWL:     result = (word << lwl_sh) | (rt_old & ((32'd1 << lwl_sh) - 32'd1));
      LWR:     result = (word >> lwr_sh) | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh));
`endif
      default: result = '0;
    endcase
  end

  always_comb begin
    merged     = word;
    byteenable = 4'b0000;
    case (op)
      SB: begin
        merged     = (word & ~(32'h0000_00FF << byte_sh)) | ({24'b0, wdata[7:0]} << byte_sh);
        byteenable = 4'b1000 >> offset;
      end
      SH: begin
        merged     = (word & ~(32'h0000_FFFF << half_sh)) | ({16'b0, wdata} << half_sh);
        byteenable = 4'b1100 >> offset;
      end
      default: begin
        merged     = word;
        byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit between datapath and a big-endian word RAM with 1-cycle read.
// Sub-word stores use read-modify-write; define MIPS_LSU_UNALIGNED_EN for LWL/LWR.
module mips_load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  mips_load_store_unit_if.slave bus
);

  if (ADDR_W != 32 || DATA_W != 32) begin : g_width_check
    $error("mips_load_store_unit supports only 32-bit address and data");
  end

  lsu_state_t  state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [1:0]  offset_q, offset_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [3:0]  be_q, be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] load_result;
  logic [31:0] merged_word;
  logic [3:0]  merge_be;
  mem_op_t     req_op;

  assign req_op = mem_op_t'(bus.req_op);

  mips_load_align u_align (
    .word       (bus.mem_rd),
    .op         (op_q),
    .offset     (offset_q),
    .rt_old     (rt_q),
    .wdata      (wdata_q),
    .result     (load_result),
    .merged     (merged_word),
    .byteenable (merge_be)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    rt_d         = rt_q;
    mem_a_d      = mem_a_q;
    mem_we_d     = 1'b0;
    mem_wd_d     = mem_wd_q;
    be_d         = 4'b0000;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d     = req_op;
          offset_d = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata[15:0];
          rt_d     = bus.req_rt_old;
          if (!is_legal(req_op) || is_misaligned(req_op, bus.req_addr[1:0])) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_op == SW) begin
            // Full-word store needs no read, so write straight away.
            state_d  = StWrite;
            mem_a_d  = {bus.req_addr[31:2], 2'b00};
            mem_we_d = 1'b1;
            mem_wd_d = bus.req_wdata;
            be_d     = 4'b1111;
          end else begin
            state_d = StAddr;
            mem_a_d = {bus.req_addr[31:2], 2'b00};
          end
        end
      end
      StAddr: state_d = StCapture;
      StCapture: begin
        if (is_store(op_q)) begin
          state_d  = StWrite;
          mem_we_d = 1'b1;
          mem_wd_d = merged_word;
          be_d     = merge_be;
        end else begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_result;
        end
      end
      StWrite: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= LB;
      offset_q     <= '0;
      wdata_q      <= '0;
      rt_q         <= '0;
      mem_a_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      rt_q         <= rt_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_wd_q     <= mem_wd_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.mem_a          = mem_a_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_wd         = mem_wd_q;
  assign bus.mem_byteenable = be_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_err       = resp_err_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit with a behavioural word RAM.
// Expected responses are queued when a request is issued and popped on resp_valid.
module tb_mips_load_store_unit;
  import mips_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  mips_load_store_unit_if bus ();

  mips_load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM: registered read, full-word write.
  logic [31:0] ram [0:15];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_a[5:2]] <= bus.mem_wd;
    bus.mem_rd <= ram[bus.mem_a[5:2]];
  end

  int          we_cnt = 0;
  logic [31:0] last_a, last_wd;
  logic [3:0]  last_be;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_a  <= bus.mem_a;
      last_wd <= bus.mem_wd;
      last_be <= bus.mem_byteenable;
    end
  end

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Drive one request and wait for its response; lat = -1 means no response.
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rt, output int lat, output logic [31:0] rdata,
                      output logic err);
    @(negedge clk);
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rt_old = rt;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (bus.resp_valid) begin
        lat   = i;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_we, bus.resp_valid, bus.resp_err, bus.mem_byteenable} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: we/rv/err/be=%b want 0000000",
               {bus.mem_we, bus.resp_valid, bus.resp_err, bus.mem_byteenable});
    end
    n_cmp++;
    if ({bus.mem_a, bus.mem_wd, bus.resp_rdata} !== 96'b0) begin
      n_bad++;
      $display("FAIL reset_data: a=%h wd=%h rdata=%h want all 0",
               bus.mem_a, bus.mem_wd, bus.resp_rdata);
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sw();
    int lat; logic [31:0] rd; logic er; exp_t e; int we0;
    we0 = we_cnt;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    send(4'(SW), 32'hBFC0_0010, 32'hDEAD_BEEF, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_bad++;
      $display("FAIL sw_resp: rdata=%h err=%b lat=%0d want %h %b %0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
    n_cmp++;
    if (we_cnt - we0 != 1 || last_a !== 32'hBFC0_0010 || last_wd !== 32'hDEAD_BEEF
        || last_be !== 4'b1111) begin
      n_bad++;
      $display("FAIL sw_write: pulses=%0d a=%h wd=%h be=%b want 1 bfc00010 deadbeef 1111",
               we_cnt - we0, last_a, last_wd, last_be);
    end
  endtask

  task automatic test_loads();
    int lat; logic [31:0] rd; logic er; exp_t e; int we0;
    vec_t v [10];
    v[0] = '{4'(LB),  32'hBFC0_0011, 0, 0, 32'hFFFF_FFF4, 1'b0, 3};
    v[1] = '{4'(LBU), 32'hBFC0_0011, 0, 0, 32'h0000_00F4, 1'b0, 3};
    v[2] = '{4'(LB),  32'hBFC0_0013, 0, 0, 32'h0000_0078, 1'b0, 3};
    v[3] = '{4'(LB),  32'hBFC0_0010, 0, 0, 32'h0000_0012, 1'b0, 3};
    v[4] = '{4'(LH),  32'hBFC0_0010, 0, 0, 32'h0000_12F4, 1'b0, 3};
    v[5] = '{4'(LHU), 32'hBFC0_0012, 0, 0, 32'h0000_5678, 1'b0, 3};
    v[6] = '{4'(LW),  32'hBFC0_0010, 0, 0, 32'h12F4_5678, 1'b0, 3};
    v[7] = '{4'(LH),  32'hBFC0_0018, 0, 0, 32'hFFFF_8001, 1'b0, 3};
    v[8] = '{4'(LHU), 32'hBFC0_0018, 0, 0, 32'h0000_8001, 1'b0, 3};
    v[9] = '{4'(LBU), 32'hBFC0_001A, 0, 0, 32'h0000_00F0, 1'b0, 3};
    send(4'(SW), 32'hBFC0_0010, 32'h12F4_5678, 32'h0, lat, rd, er);
    send(4'(SW), 32'hBFC0_0018, 32'h8001_F0F0, 32'h0, lat, rd, er);
    we0 = we_cnt;
    foreach (v[i]) begin
      exp_q.push_back('{rdata: v[i].rdata, err: v[i].err, lat: v[i].lat});
      send(v[i].op, v[i].addr, v[i].wdata, v[i].rt, lat, rd, er);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_bad++;
        $display("FAIL load[%0d] op=%0d addr=%h: rdata=%h err=%b lat=%0d want %h %b %0d",
                 i, v[i].op, v[i].addr, rd, er, lat, e.rdata, e.err, e.lat);
      end
    end
    n_cmp++;
    if (we_cnt != we0) begin
      n_bad++;
      $display("FAIL load_no_write: pulses=%0d want 0", we_cnt - we0);
    end
  endtask

  task automatic test_subword_store();
    int lat; logic [31:0] rd; logic er; exp_t e; int we0;
    send(4'(SW), 32'hBFC0_0014, 32'h1122_3344, 32'h0, lat, rd, er);
    we0 = we_cnt;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 4});
    send(4'(SH), 32'hBFC0_0016, 32'h0000_ABCD, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_bad++;
      $display("FAIL sh_resp: rdata=%h err=%b lat=%0d want %h %b %0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
    n_cmp++;
    if (we_cnt - we0 != 1 || last_a !== 32'hBFC0_0014 || last_wd !== 32'h1122_ABCD
        || last_be !== 4'b0011) begin
      n_bad++;
      $display("FAIL sh_write: pulses=%0d a=%h wd=%h be=%b want 1 bfc00014 1122abcd 0011",
               we_cnt - we0, last_a, last_wd, last_be);
    end
    we0 = we_cnt;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 4});
    send(4'(SB), 32'hBFC0_0015, 32'hFFFF_FF5A, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || we_cnt - we0 != 1
        || last_wd !== 32'h115A_ABCD || last_be !== 4'b0100) begin
      n_bad++;
      $display("FAIL sb_write: rdata=%h lat=%0d pulses=%0d wd=%h be=%b want 0 4 1 115aabcd 0100",
               rd, lat, we_cnt - we0, last_wd, last_be);
    end
    exp_q.push_back('{rdata: 32'h115A_ABCD, err: 1'b0, lat: 3});
    send(4'(LW), 32'hBFC0_0014, 32'h0, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_bad++;
      $display("FAIL rmw_readback: rdata=%h err=%b lat=%0d want %h %b %0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; exp_t e; int we0;
    logic [3:0]  ops   [8];
    logic [31:0] addrs [8];
    ops = '{4'(LW), 4'(LH), 4'(LHU), 4'(SH), 4'(SW), 4'(SW), 4'd7, 4'd15};
    addrs = '{32'hBFC0_0002, 32'hBFC0_0011, 32'hBFC0_0013, 32'hBFC0_0015,
              32'hBFC0_0011, 32'hBFC0_0012, 32'hBFC0_0010, 32'hBFC0_0010};
    we0 = we_cnt;
    foreach (ops[i]) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      send(ops[i], addrs[i], 32'h5555_5555, 32'h0, lat, rd, er);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_bad++;
        $display("FAIL err[%0d] op=%0d addr=%h: rdata=%h err=%b lat=%0d want %h %b %0d",
                 i, ops[i], addrs[i], rd, er, lat, e.rdata, e.err, e.lat);
      end
    end
    n_cmp++;
    if (we_cnt != we0) begin
      n_bad++;
      $display("FAIL err_no_write: pulses=%0d want 0", we_cnt - we0);
    end
    // Still in RESP at this negedge, back in IDLE one cycle later.
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_in_resp: got %b want 0", bus.req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_resp: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er; exp_t e; int we0;
    send(4'(SW), 32'hBFC0_0018, 32'hCAFE_F00D, 32'h0, lat, rd, er);
    we0 = we_cnt;
    @(negedge clk);
    bus.req_op    = 4'(SB);
    bus.req_addr  = 32'hBFC0_0019;
    bus.req_wdata = 32'h0000_0055;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk);                     // accept -> ADDR
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);                     // -> CAPTURE
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_we, bus.resp_valid, bus.resp_err, bus.mem_byteenable, bus.req_ready}
        !== 8'b0000_0001 || {bus.mem_a, bus.mem_wd, bus.resp_rdata} !== 96'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: we=%b rv=%b err=%b be=%b rdy=%b a=%h wd=%h rd=%h",
               bus.mem_we, bus.resp_valid, bus.resp_err, bus.mem_byteenable, bus.req_ready,
               bus.mem_a, bus.mem_wd, bus.resp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (we_cnt != we0) begin
      n_bad++;
      $display("FAIL abort_no_write: pulses=%0d want 0", we_cnt - we0);
    end
    exp_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, lat: 3});
    send(4'(LW), 32'hBFC0_0018, 32'h0, 32'h0, lat, rd, er);
    e = exp_q.pop_front();
    n_cmp++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
      n_bad++;
      $display("FAIL abort_readback: rdata=%h err=%b lat=%0d want %h %b %0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
  endtask

  task automatic test_unaligned();
    int lat; logic [31:0] rd; logic er; exp_t e; int we0;
    logic [3:0] ops [2];
    ops = '{4'(LWL), 4'(LWR)};
    send(4'(SW), 32'hBFC0_001C, 32'h1122_3344, 32'h0, lat, rd, er);
    we0 = we_cnt;
`ifdef MIPS_LSU_UNALIGNED_EN
    exp_q.push_back('{rdata: 32'h2233_44DD, err: 1'b0, lat: 3});
    exp_q.push_back('{rdata: 32'hAABB_1122, err: 1'b0, lat: 3});
`else
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
`endif
    foreach (ops[i]) begin
      send(ops[i], 32'hBFC0_001D, 32'h0, 32'hAABB_CCDD, lat, rd, er);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_bad++;
        $display("FAIL unaligned op=%0d: rdata=%h err=%b lat=%0d want %h %b %0d",
                 ops[i], rd, er, lat, e.rdata, e.err, e.lat);
      end
    end
    n_cmp++;
    if (we_cnt != we0) begin
      n_bad++;
      $display("FAIL unaligned_no_write: pulses=%0d want 0", we_cnt - we0);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er; exp_t e;
    logic [3:0]  ops   [4];
    logic [31:0] addrs [4];
    logic [31:0] wds   [4];
    ops   = '{4'(SW), 4'(LBU), 4'(SB), 4'(LW)};
    addrs = '{32'hBFC0_0020, 32'hBFC0_0022, 32'hBFC0_0023, 32'hBFC0_0020};
    wds   = '{32'h0102_0304, 32'h0, 32'h0000_0099, 32'h0};
    exp_q.push_back('{rdata: 32'h0,         err: 1'b0, lat: 2});
    exp_q.push_back('{rdata: 32'h0000_0003, err: 1'b0, lat: 3});
    exp_q.push_back('{rdata: 32'h0,         err: 1'b0, lat: 4});
    exp_q.push_back('{rdata: 32'h0102_0399, err: 1'b0, lat: 3});
    foreach (ops[i]) begin
      send(ops[i], addrs[i], wds[i], 32'h0, lat, rd, er);
      e = exp_q.pop_front();
      n_cmp++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_bad++;
        $display("FAIL b2b[%0d] op=%0d: rdata=%h err=%b lat=%0d want %h %b %0d",
                 i, ops[i], rd, er, lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rt_old = '0;
    test_reset();
    test_sw();
    test_loads();
    test_subword_store();
    test_errors();
    test_reset_abort();
    test_unaligned();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
